// File: rtl/lcd_multi_display.sv
// HD44780 16x2 character-LCD driver: shows up to four channel values in decimal or hex.
// Owns power-up wait, controller init, sequential binary-to-BCD conversion and periodic refresh.
module lcd_multi_display #(
  parameter int NUM_CH         = 3,
  parameter int VAL_WIDTH      = 8,
  parameter int DIGITS         = 3,
  parameter int POWERUP_CYCLES = 750000,
  parameter int EN_CYCLES      = 25,
  parameter int CMD_WAIT       = 2000,
  parameter int CLEAR_WAIT     = 100000,
  parameter int REFRESH_CYCLES = 2500000
) (
  input  logic                        clock_50,
  input  logic                        reset_n,
  input  logic [NUM_CH*VAL_WIDTH-1:0] values,
  input  logic [NUM_CH-1:0]           hex_mode,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        LCD_ON,
  output logic                        LCD_BLON,
  output logic                        LCD_RW,
  output logic                        LCD_EN,
  output logic                        LCD_RS,
  output logic [7:0]                  LCD_DATA
);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_SNAP, S_CONV, S_FRAME, S_IDLE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = (VAL_WIDTH > 1) ? $clog2(VAL_WIDTH) : 1;

  state_t              r_state, w_state_next;
  phase_t              r_ph, w_ph_next;
  logic [31:0]         r_cnt, w_cnt_next, w_wait;
  logic [5:0]          r_idx, w_idx_next;
  logic [CH_W-1:0]     r_ch, w_ch_next;
  logic [BIT_W-1:0]    r_bit, w_bit_next;
  logic                r_en, w_en_next, r_rs, w_rs_next;
  logic [7:0]          r_data, w_data_next, w_char;
  logic                w_load, w_frame_done, w_last, w_ch_hex, w_in_bit, w_conv_done;

  logic [NUM_CH*VAL_WIDTH-1:0] r_snap_val;
  logic [NUM_CH-1:0]           r_snap_hex;
  logic [VAL_WIDTH-1:0]        w_cur_val;
  logic [BCD_W-1:0]            r_bcd, w_adj, w_bcd_step, w_hex;
  logic [BCD_W-1:0]            r_dig [NUM_CH];

  function automatic logic [7:0] glyph(input logic [3:0] d);
    return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
  endfunction

  assign w_cur_val = VAL_WIDTH'(r_snap_val >> (int'(r_ch) * VAL_WIDTH));
  assign w_ch_hex  = 1'(r_snap_hex >> r_ch);
  assign w_in_bit  = 1'(w_cur_val >> (VAL_WIDTH - 1 - int'(r_bit)));

  // Double dabble step on a DIGITS-wide BCD register; carries out of the top digit
  // are dropped, which leaves the value modulo 10^DIGITS.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                           : r_bcd[gi*4 +: 4];
    end
    for (genvar gi = 0; gi < BCD_W; gi++) begin : g_hex
      if (gi < VAL_WIDTH) begin : g_bit
        assign w_hex[gi] = w_cur_val[gi];
      end else begin : g_zero
        assign w_hex[gi] = 1'b0;
      end
    end
  endgenerate
  assign w_bcd_step = BCD_W'({w_adj, w_in_bit});

  assign w_last      = (r_state == S_INIT) ? (r_idx == 6'd3) : (r_idx == 6'd33);
  assign w_wait      = (r_state == S_INIT && r_idx == 6'd3) ? 32'(CLEAR_WAIT) : 32'(CMD_WAIT);
  assign w_conv_done = w_ch_hex || (r_bit == BIT_W'(VAL_WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    w_ph_next    = r_ph;
    w_cnt_next   = r_cnt + 32'd1;
    w_idx_next   = r_idx;
    w_ch_next    = r_ch;
    w_bit_next   = r_bit;
    w_en_next    = r_en;
    w_load       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_PWR: begin
        if (r_cnt == 32'(POWERUP_CYCLES - 1)) begin
          w_state_next = S_INIT;
          w_ph_next    = PH_SETUP;
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_load       = 1'b1;
        end
      end
      S_INIT, S_FRAME: begin
        case (r_ph)
          PH_SETUP: begin
            w_ph_next  = PH_EN;
            w_cnt_next = '0;
            w_en_next  = 1'b1;
          end
          PH_EN: begin
            if (r_cnt == 32'(EN_CYCLES - 1)) begin
              w_ph_next  = PH_WAIT;
              w_cnt_next = '0;
              w_en_next  = 1'b0;
            end
          end
          PH_WAIT: begin
            if (r_cnt == w_wait - 32'd1) begin
              w_cnt_next = '0;
              if (!w_last) begin
                w_idx_next = r_idx + 6'd1;
                w_ph_next  = PH_SETUP;
                w_load     = 1'b1;
              end else if (r_state == S_INIT) begin
                w_state_next = S_SNAP;
              end else begin
                w_state_next = S_IDLE;
                w_frame_done = 1'b1;
              end
            end
          end
          default: w_ph_next = PH_SETUP;
        endcase
      end
      S_SNAP: begin
        w_state_next = S_CONV;
        w_ch_next    = '0;
        w_bit_next   = '0;
        w_cnt_next   = '0;
      end
      S_CONV: begin
        if (w_conv_done) begin
          w_bit_next = '0;
          if (r_ch == CH_W'(NUM_CH - 1)) begin
            w_state_next = S_FRAME;
            w_ph_next    = PH_SETUP;
            w_idx_next   = '0;
            w_cnt_next   = '0;
            w_load       = 1'b1;
          end else begin
            w_ch_next = r_ch + CH_W'(1);
          end
        end else begin
          w_bit_next = r_bit + BIT_W'(1);
        end
      end
      S_IDLE: begin
        if (r_cnt == 32'(REFRESH_CYCLES - 1)) begin
          w_state_next = S_SNAP;
          w_cnt_next   = '0;
        end
      end
      default: w_state_next = S_PWR;
    endcase
  end

  // Frame write index: 0 = line-1 address, 1..16 = line 1, 17 = line-2 address, 18..33 = line 2.
  always_comb begin
    int line_i;
    int col;
    int start;
    w_char = 8'h20;
    line_i = (w_idx_next >= 6'd17) ? 1 : 0;
    col    = (line_i == 1) ? int'(w_idx_next) - 18 : int'(w_idx_next) - 1;
    for (int k = 0; k < NUM_CH; k++) begin
      start = (k % 2) * 8;
      if ((k / 2) == line_i && col >= start && col < start + DIGITS && col < 16) begin
        w_char = glyph(4'(r_dig[k] >> (4 * (DIGITS - 1 - (col - start)))));
      end
    end
  end

  always_comb begin
    w_rs_next   = r_rs;
    w_data_next = r_data;
    if (w_load) begin
      if (w_state_next == S_INIT) begin
        w_rs_next = 1'b0;
        case (w_idx_next[1:0])
          2'd0:    w_data_next = 8'h38;
          2'd1:    w_data_next = 8'h0C;
          2'd2:    w_data_next = 8'h06;
          default: w_data_next = 8'h01;
        endcase
      end else if (w_idx_next == 6'd0) begin
        w_rs_next   = 1'b0;
        w_data_next = 8'h80;
      end else if (w_idx_next == 6'd17) begin
        w_rs_next   = 1'b0;
        w_data_next = 8'hC0;
      end else begin
        w_rs_next   = 1'b1;
        w_data_next = w_char;
      end
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_PWR;
      r_ph    <= PH_SETUP;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ch    <= '0;
      r_bit   <= '0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_ph    <= w_ph_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_ch    <= w_ch_next;
      r_bit   <= w_bit_next;
      r_en    <= w_en_next;
      r_rs    <= w_rs_next;
      r_data  <= w_data_next;
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_snap_val <= '0;
      r_snap_hex <= '0;
      r_bcd      <= '0;
      for (int k = 0; k < NUM_CH; k++) r_dig[k] <= '0;
    end else if (r_state == S_SNAP) begin
      r_snap_val <= values;
      r_snap_hex <= hex_mode;
      r_bcd      <= '0;
    end else if (r_state == S_CONV) begin
      if (w_ch_hex) begin
        r_dig[r_ch] <= w_hex;
        r_bcd       <= '0;
      end else if (w_conv_done) begin
        r_dig[r_ch] <= w_bcd_step;
        r_bcd       <= '0;
      end else begin
        r_bcd <= w_bcd_step;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign frame_done = w_frame_done;
  assign LCD_ON     = 1'b1;
  assign LCD_BLON   = 1'b1;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = r_en;
  assign LCD_RS     = r_rs;
  assign LCD_DATA   = r_data;

endmodule
